// File: rtl/wb_cpu_pkg.sv
// Shared types for the Atari 2600 Wishbone initiator and its address decoder.
package wb_cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_ROM = 2'd0,
      SEL_TIA = 2'd1,
      SEL_RAM = 2'd2,
      SEL_PIA = 2'd3
   } sel_t;

   localparam logic [7:0] RD_ERR_DATA = 8'hFF;

   // Bit order matches {pia, ram, tia, rom} strobe/ack vectors.
   function automatic logic [3:0] sel_onehot(input sel_t s);
      sel_onehot = 4'b0001 << s;
   endfunction

endpackage

// File: rtl/atari_addr_decode.sv
// Maps a 13-bit 6502 address to a slave select and the 12-bit slave-local address.
module atari_addr_decode
   import wb_cpu_pkg::*;
(
   input  logic [12:0] adr_i,
   output sel_t        sel_o,
   output logic [11:0] slv_adr_o
);

   // Priority: A12 selects ROM, then A7 splits TIA off, then A9 splits RAM from PIA.
   always_comb begin
      sel_o     = SEL_TIA;
      slv_adr_o = {5'b0, adr_i[6:0]};
      if (adr_i[12]) begin
         sel_o     = SEL_ROM;
         slv_adr_o = adr_i[11:0];
      end else if (!adr_i[7]) begin
         sel_o = SEL_TIA;
      end else if (!adr_i[9]) begin
         sel_o = SEL_RAM;
      end else begin
         sel_o = SEL_PIA;
      end
   end

endmodule

// File: rtl/wb_cpu_master.sv
// Wishbone classic initiator: one CPU byte access per cycle, decoded to ROM/TIA/RAM/PIA,
// completed by the selected slave's ack or by a timeout that returns 0xFF.
module wb_cpu_master
   import wb_cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [12:0] cpu_adr,
   input  logic [7:0]  cpu_dat_w,
   output logic [7:0]  cpu_dat_r,
   output logic        cpu_rdy,
   output logic        bus_err,
   output logic [11:0] adr_o,
   output logic [7:0]  dat_o,
   output logic        we_o,
   output logic        rom_stb_o,
   output logic        tia_stb_o,
   output logic        ram_stb_o,
   output logic        pia_stb_o,
   input  logic        rom_ack_i,
   input  logic        tia_ack_i,
   input  logic        ram_ack_i,
   input  logic        pia_ack_i,
   input  logic [7:0]  rom_dat_i,
   input  logic [7:0]  tia_dat_i,
   input  logic [7:0]  ram_dat_i,
   input  logic [7:0]  pia_dat_i
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   sel_t        w_dec_sel;
   logic [11:0] w_dec_adr;
   logic [3:0]  w_ack_vec;
   logic [7:0]  w_dat_vec [4];
   logic        w_ack;
   logic [7:0]  w_dat;

   state_t      r_state;
   sel_t        r_sel;
   logic [7:0]  r_cnt;
   logic [3:0]  r_stb;
   logic [11:0] r_adr;
   logic [7:0]  r_wdat;
   logic        r_we;
   logic [7:0]  r_rdat;
   logic        r_rdy;
   logic        r_err;

   atari_addr_decode u_decode (
      .adr_i     (cpu_adr),
      .sel_o     (w_dec_sel),
      .slv_adr_o (w_dec_adr)
   );

   // Only the latched slave is ever looked at, so stray acks elsewhere are harmless.
   assign w_ack_vec    = {pia_ack_i, ram_ack_i, tia_ack_i, rom_ack_i};
   assign w_dat_vec[0] = rom_dat_i;
   assign w_dat_vec[1] = tia_dat_i;
   assign w_dat_vec[2] = ram_dat_i;
   assign w_dat_vec[3] = pia_dat_i;
   assign w_ack        = w_ack_vec[r_sel];
   assign w_dat        = w_dat_vec[r_sel];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_sel   <= SEL_ROM;
         r_cnt   <= 8'd0;
         r_stb   <= 4'b0000;
         r_adr   <= 12'd0;
         r_wdat  <= 8'd0;
         r_we    <= 1'b0;
         r_rdat  <= 8'd0;
         r_rdy   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cpu_req) begin
                  r_sel   <= w_dec_sel;
                  r_adr   <= w_dec_adr;
                  r_wdat  <= cpu_dat_w;
                  r_we    <= cpu_we;
                  r_stb   <= sel_onehot(w_dec_sel);
                  r_cnt   <= 8'd0;
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // Ack is tested first so a late ack on the timeout cycle still succeeds.
               if (w_ack) begin
                  if (!r_we) begin
                     r_rdat <= w_dat;
                  end
                  r_stb   <= 4'b0000;
                  r_rdy   <= 1'b1;
                  r_state <= ST_RECOVER;
               end else if (r_cnt == CNT_LAST) begin
                  if (!r_we) begin
                     r_rdat <= RD_ERR_DATA;
                  end
                  r_stb   <= 4'b0000;
                  r_rdy   <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= ST_RECOVER;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_RECOVER: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_stb   <= 4'b0000;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_dat_r = r_rdat;
   assign cpu_rdy   = r_rdy;
   assign bus_err   = r_err;
   assign adr_o     = r_adr;
   assign dat_o     = r_wdat;
   assign we_o      = r_we;
   assign rom_stb_o = r_stb[0];
   assign tia_stb_o = r_stb[1];
   assign ram_stb_o = r_stb[2];
   assign pia_stb_o = r_stb[3];

endmodule
